// File: rtl/bn_pkg.sv
// Shared types, Q-format constants and saturation helper for the
// batch-norm + activation pipeline.
`default_nettype none

package bn_pkg;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_RELU6  = 2'b10,
        ACT_HSWISH = 2'b11
    } act_mode_t;

    // Integer magnitudes; shift left by FRAC at the point of use to obtain Q-format.
    localparam int ONE   = 1;
    localparam int THREE = 3;
    localparam int SIX   = 6;
    localparam int INV6  = 10923;

    // Clamp a wide signed value into the range of a w-bit two's-complement number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            sat = hi;
        else if (v < lo)
            sat = lo;
        else
            sat = v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bn_act_unit.sv
// Final pipeline stage: applies the per-sample activation and holds the
// output register under the global stall.
`default_nettype none

module bn_act_unit
    import bn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int CH_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    advance,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_sat,
    input  logic [CH_W-1:0]         in_channel,
    input  act_mode_t               in_mode,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]         out_channel,
    output logic                    out_sat
);

    localparam logic signed [63:0] THREE_Q = 64'(THREE) <<< FRAC;
    localparam logic signed [63:0] SIX_Q   = 64'(SIX) <<< FRAC;
    localparam logic signed [63:0] INV6_W  = 64'(INV6);

    logic signed [63:0]      y_w;
    logic signed [63:0]      t_w;
    logic signed [63:0]      p_w;
    logic signed [63:0]      h_w;
    logic signed [WIDTH-1:0] act_w;

    logic                    valid_q;
    logic signed [WIDTH-1:0] data_q;
    logic [CH_W-1:0]         channel_q;
    logic                    sat_q;

    always_comb begin
        y_w = 64'(in_data);
        t_w = y_w + THREE_Q;
        if (t_w < 0)
            t_w = '0;
        else if (t_w > SIX_Q)
            t_w = SIX_Q;
        p_w = (y_w * t_w) >>> FRAC;
        h_w = (p_w * INV6_W) >>> 16;

        act_w = in_data;
        case (in_mode)
            ACT_RELU: begin
                if (y_w < 0)
                    act_w = '0;
            end
            ACT_RELU6: begin
                if (y_w < 0)
                    act_w = '0;
                else if (y_w > SIX_Q)
                    act_w = WIDTH'(SIX_Q);
            end
            ACT_HSWISH: act_w = WIDTH'(sat(h_w, WIDTH));
            default:    act_w = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q   <= in_valid;
            data_q    <= act_w;
            channel_q <= in_channel;
            sat_q     <= in_sat;
        end
    end

    // Payload reads as zero whenever no sample is presented.
    assign out_valid   = valid_q;
    assign out_data    = valid_q ? data_q : '0;
    assign out_channel = valid_q ? channel_q : '0;
    assign out_sat     = valid_q & sat_q;

endmodule

`default_nettype wire

// File: rtl/batchnorm_act_pipe.sv
// Four-stage folded batch-norm (scale/bias per channel) with round/saturate
// and selectable activation, under a single global stall.
`default_nettype none

module batchnorm_act_pipe
    import bn_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int CHANNELS = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              act_mode,
    input  logic                    prm_we,
    input  logic [CH_W-1:0]         prm_addr,
    input  logic signed [WIDTH-1:0] prm_scale,
    input  logic signed [WIDTH-1:0] prm_bias,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic [CH_W-1:0]         s_channel,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic [CH_W-1:0]         m_channel,
    output logic                    m_sat
);

    localparam int ACC_W = 2 * WIDTH + 2;
    localparam logic signed [WIDTH-1:0] ONE_Q  = WIDTH'(ONE <<< FRAC);
    localparam logic signed [ACC_W-1:0] HALF_Q = ACC_W'(1) <<< (FRAC - 1);

    logic signed [WIDTH-1:0] scale_tbl [CHANNELS];
    logic signed [WIDTH-1:0] bias_tbl  [CHANNELS];
    logic signed [WIDTH-1:0] rd_scale;
    logic signed [WIDTH-1:0] rd_bias;
    logic                    prm_hit;
    logic                    ch_hit;

    logic advance;
    logic accept;

    logic                    v1, v2, v3;
    logic signed [WIDTH-1:0] x1, sc1, bi1;
    logic signed [ACC_W-1:0] acc2;
    logic signed [WIDTH-1:0] y3;
    logic                    sat3;
    logic [CH_W-1:0]         ch1, ch2, ch3;
    act_mode_t               md1, md2, md3;

    logic signed [ACC_W-1:0] acc_w;
    logic signed [ACC_W-1:0] shr_w;
    logic signed [63:0]      wide_w;
    logic signed [63:0]      sat_w;
    logic signed [WIDTH-1:0] y_w;
    logic                    clamp_w;

    assign prm_hit = int'(prm_addr) < CHANNELS;
    assign ch_hit  = int'(s_channel) < CHANNELS;

    // Writes land at the edge, so a same-cycle lookup still sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                scale_tbl[i] <= ONE_Q;
                bias_tbl[i]  <= '0;
            end
        end else if (prm_we && prm_hit) begin
            scale_tbl[prm_addr] <= prm_scale;
            bias_tbl[prm_addr]  <= prm_bias;
        end
    end

    always_comb begin
        rd_scale = ONE_Q;
        rd_bias  = '0;
        if (ch_hit) begin
            rd_scale = scale_tbl[s_channel];
            rd_bias  = bias_tbl[s_channel];
        end
    end

    assign advance = rst_n && en && (!m_valid || m_ready);
    assign s_ready = advance;
    assign accept  = s_valid && advance;

    assign acc_w   = ACC_W'(x1) * ACC_W'(sc1) + (ACC_W'(bi1) <<< FRAC) + HALF_Q;
    assign shr_w   = acc2 >>> FRAC;
    assign wide_w  = 64'(shr_w);
    assign sat_w   = sat(wide_w, WIDTH);
    assign y_w     = WIDTH'(sat_w);
    assign clamp_w = (sat_w != wide_w);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (advance) begin
            v1   <= accept;
            x1   <= s_data;
            sc1  <= rd_scale;
            bi1  <= rd_bias;
            ch1  <= s_channel;
            md1  <= act_mode_t'(act_mode);

            v2   <= v1;
            acc2 <= acc_w;
            ch2  <= ch1;
            md2  <= md1;

            v3   <= v2;
            y3   <= y_w;
            sat3 <= clamp_w;
            ch3  <= ch2;
            md3  <= md2;
        end
    end

    bn_act_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .CH_W  (CH_W)
    ) u_act (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .in_valid    (v3),
        .in_data     (y3),
        .in_sat      (sat3),
        .in_channel  (ch3),
        .in_mode     (md3),
        .out_valid   (m_valid),
        .out_data    (m_data),
        .out_channel (m_channel),
        .out_sat     (m_sat)
    );

endmodule

`default_nettype wire

// File: tb/tb_batchnorm_act_pipe.sv
// Directed self-checking bench for batchnorm_act_pipe (WIDTH=16, FRAC=8, CHANNELS=12).
`default_nettype none

module tb_batchnorm_act_pipe;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  act_mode;
    logic        prm_we;
    logic [3:0]  prm_addr;
    logic [15:0] prm_scale;
    logic [15:0] prm_bias;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [3:0]  s_channel;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [3:0]  m_channel;
    logic        m_sat;

    int checks = 0;
    int passed = 0;

    batchnorm_act_pipe #(
        .WIDTH    (16),
        .FRAC     (8),
        .CHANNELS (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .act_mode  (act_mode),
        .prm_we    (prm_we),
        .prm_addr  (prm_addr),
        .prm_scale (prm_scale),
        .prm_bias  (prm_bias),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_channel (s_channel),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_channel (m_channel),
        .m_sat     (m_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sat, data} for channel 3 programmed as scale=2.0, bias=0.5:
    // y = 2x + 128 (exact), clamped to 16 bits, then the activation.
    function automatic logic [16:0] ref_ch3(input logic [15:0] x, input logic [1:0] mode);
        longint y;
        longint t;
        longint h;
        logic   s;
        y = 2 * longint'($signed(x)) + 128;
        s = 1'b0;
        if (y > 32767) begin y = 32767; s = 1'b1; end
        else if (y < -32768) begin y = -32768; s = 1'b1; end
        case (mode)
            2'd1: if (y < 0) y = 0;
            2'd2: begin if (y < 0) y = 0; else if (y > 1536) y = 1536; end
            2'd3: begin
                t = y + 768;
                if (t < 0) t = 0;
                if (t > 1536) t = 1536;
                h = (y * t) >>> 8;
                h = (h * 10923) >>> 16;
                if (h > 32767) h = 32767;
                if (h < -32768) h = -32768;
                y = h;
            end
            default: ;
        endcase
        return {s, y[15:0]};
    endfunction

    task automatic write_prm(input logic [3:0] addr, input logic [15:0] sc, input logic [15:0] bi);
        @(posedge clk); #1;
        prm_we = 1'b1; prm_addr = addr; prm_scale = sc; prm_bias = bi;
        @(posedge clk); #1;
        prm_we = 1'b0;
    endtask

    // Drives one sample (optionally with a same-cycle table write) and captures the result.
    task automatic send_cap(input logic [15:0] x, input logic [3:0] ch, input logic [1:0] mode,
                            input logic we, input logic [3:0] waddr,
                            input logic [15:0] wscale, input logic [15:0] wbias,
                            output int lat, output logic [15:0] d, output logic sat,
                            output logic [3:0] och);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = x; s_channel = ch; act_mode = mode;
        prm_we = we; prm_addr = waddr; prm_scale = wscale; prm_bias = wbias;
        @(posedge clk); #1;
        s_valid = 1'b0; prm_we = 1'b0;
        lat = -1; d = '0; sat = 1'b0; och = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (m_valid) begin
                lat = k; d = m_data; sat = m_sat; och = m_channel;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; act_mode = 2'd0;
        prm_we = 1'b0; prm_addr = '0; prm_scale = '0; prm_bias = '0;
        s_valid = 1'b1; s_data = 16'h1234; s_channel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", m_valid); else passed++;
        checks++; if (m_data !== 16'h0) $display("FAIL rst_m_data: got %h expected 0000", m_data); else passed++;
        checks++; if (m_channel !== 4'h0) $display("FAIL rst_m_channel: got %h expected 0", m_channel); else passed++;
        checks++; if (m_sat !== 1'b0) $display("FAIL rst_m_sat: got %b expected 0", m_sat); else passed++;
        checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b expected 0", s_ready); else passed++;
        @(posedge clk); #1;
        s_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %b expected 1", s_ready); else passed++;
    endtask

    task automatic test_enable();
        logic bad;
        int   lat;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 16'h0040; s_channel = 4'd0; act_mode = 2'd0;
        @(posedge clk); #1;
        s_valid = 1'b0; en = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid || s_ready) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) $display("FAIL en_freeze: got activity=%b expected 0", bad); else passed++;
        @(posedge clk); #1;
        en = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid) begin lat = k; break; end
        end
        checks++; if (lat !== 3) $display("FAIL en_resume_lat: got %0d expected 3", lat); else passed++;
        checks++; if (m_data !== 16'h0040) $display("FAIL en_resume_data: got %h expected 0040", m_data); else passed++;
    endtask

    task automatic test_basic();
        int lat; logic [15:0] d; logic s; logic [3:0] c;
        write_prm(4'd3, 16'h0200, 16'h0080);
        send_cap(16'h0100, 4'd3, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (lat !== 4) $display("FAIL basic_lat: got %0d expected 4", lat); else passed++;
        checks++; if (d !== 16'h0280) $display("FAIL basic_data: got %h expected 0280", d); else passed++;
        checks++; if (s !== 1'b0) $display("FAIL basic_sat: got %b expected 0", s); else passed++;
        checks++; if (c !== 4'd3) $display("FAIL basic_channel: got %0d expected 3", c); else passed++;
        send_cap(16'hFF00, 4'd3, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'hFE80) $display("FAIL basic_neg_data: got %h expected fe80", d); else passed++;
    endtask

    task automatic test_saturation();
        int lat; logic [15:0] d; logic s; logic [3:0] c;
        write_prm(4'd1, 16'h7FFF, 16'h0000);
        send_cap(16'h7FFF, 4'd1, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h7FFF || s !== 1'b1) $display("FAIL sat_pos: got %h/%b expected 7fff/1", d, s); else passed++;
        send_cap(16'h8000, 4'd1, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h8000 || s !== 1'b1) $display("FAIL sat_neg: got %h/%b expected 8000/1", d, s); else passed++;
        // scale=0.5 exposes round-half-up at +/- half an LSB
        write_prm(4'd2, 16'h0080, 16'h0000);
        send_cap(16'h0001, 4'd2, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h0001 || s !== 1'b0) $display("FAIL round_pos: got %h/%b expected 0001/0", d, s); else passed++;
        send_cap(16'hFFFF, 4'd2, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h0000) $display("FAIL round_neg: got %h expected 0000", d); else passed++;
    endtask

    task automatic test_activation();
        logic [15:0] xs [8];
        logic [1:0]  ms [8];
        logic [15:0] es [8];
        int lat; logic [15:0] d; logic s; logic [3:0] c;
        xs = '{16'hFF00, 16'h0123, 16'h0800, 16'hFF00, 16'h0100, 16'hFE00, 16'hFC00, 16'h0800};
        ms = '{2'd1,     2'd1,     2'd2,     2'd2,     2'd3,     2'd3,     2'd3,     2'd3};
        es = '{16'h0000, 16'h0123, 16'h0600, 16'h0000, 16'h00AA, 16'hFFAA, 16'h0000, 16'h0800};
        for (int i = 0; i < 8; i++) begin
            send_cap(xs[i], 4'd0, ms[i], 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
            checks++;
            if (d !== es[i] || lat !== 4)
                $display("FAIL act_%0d: got %h lat %0d expected %h lat 4", i, d, lat, es[i]);
            else
                passed++;
        end
    endtask

    task automatic test_param_timing();
        int lat; logic [15:0] d; logic s; logic [3:0] c;
        send_cap(16'h0100, 4'd5, 2'd0, 1'b1, 4'd5, 16'h0300, 16'h0000, lat, d, s, c);
        checks++; if (d !== 16'h0100) $display("FAIL same_cycle_old: got %h expected 0100", d); else passed++;
        send_cap(16'h0100, 4'd5, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h0300) $display("FAIL next_uses_new: got %h expected 0300", d); else passed++;
        write_prm(4'd13, 16'h0300, 16'h0100);
        send_cap(16'h1234, 4'd12, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h1234 || c !== 4'd12) $display("FAIL oob_ch12: got %h ch %0d expected 1234 ch 12", d, c); else passed++;
        send_cap(16'h1234, 4'd13, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h1234) $display("FAIL oob_write_ignored: got %h expected 1234", d); else passed++;
    endtask

    task automatic test_stream();
        logic [16:0] exp_q [$];
        logic [16:0] e;
        int   sent, got, cyc;
        logic in_fire, out_fire;
        logic held_v, held_s;
        logic [15:0] held_d;
        logic [3:0]  held_c;
        sent = 0; got = 0; cyc = 0; held_v = 1'b0;
        held_s = 1'b0; held_d = '0; held_c = '0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 16'($urandom); s_channel = 4'd3; act_mode = 2'd0;
        while (got < 32 && cyc < 600) begin
            @(negedge clk);
            if (held_v) begin
                checks++;
                if (!m_valid || m_data !== held_d || m_sat !== held_s || m_channel !== held_c)
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_valid, m_data, held_d);
                else
                    passed++;
            end
            if (cyc >= 10 && cyc < 15) m_ready = 1'b0;
            else m_ready = 1'($urandom_range(0, 1));
            #1;
            in_fire  = s_valid && s_ready;
            out_fire = m_valid && m_ready;
            if (in_fire) exp_q.push_back(ref_ch3(s_data, act_mode));
            if (out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got %h expected no output", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_sat, m_data} !== e || m_channel !== 4'd3)
                        $display("FAIL stream_%0d: got %b/%h expected %b/%h", got, m_sat, m_data, e[16], e[15:0]);
                    else
                        passed++;
                end
                got++;
            end
            held_v = m_valid && !m_ready;
            held_d = m_data; held_s = m_sat; held_c = m_channel;
            @(posedge clk); #1;
            if (in_fire) begin
                sent++;
                if (sent < 32) begin
                    s_data = 16'($urandom); act_mode = 2'(sent % 4);
                end else begin
                    s_valid = 1'b0;
                end
            end
            cyc++;
        end
        checks++; if (got !== 32) $display("FAIL stream_count: got %0d expected 32", got); else passed++;
        m_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        logic bad;
        int lat; logic [15:0] d; logic s; logic [3:0] c;
        write_prm(4'd4, 16'h0300, 16'h0000);
        @(posedge clk); #1;
        s_valid = 1'b1; s_channel = 4'd4; act_mode = 2'd0; s_data = 16'h0100;
        @(posedge clk); #1;
        s_data = 16'h0200;
        @(posedge clk); #1;
        s_data = 16'h0300;
        @(posedge clk); #1;
        s_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m_valid) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) $display("FAIL flush_no_valid: got valid seen=%b expected 0", bad); else passed++;
        checks++; if (m_data !== 16'h0 || m_channel !== 4'h0) $display("FAIL idle_zero: got %h ch %0d expected 0000 ch 0", m_data, m_channel); else passed++;
        send_cap(16'h0100, 4'd4, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h0100 || lat !== 4) $display("FAIL table_reset_ch4: got %h lat %0d expected 0100 lat 4", d, lat); else passed++;
        send_cap(16'h0100, 4'd3, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, lat, d, s, c);
        checks++; if (d !== 16'h0100) $display("FAIL table_reset_ch3: got %h expected 0100", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_basic();
        test_saturation();
        test_activation();
        test_param_timing();
        test_stream();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/batchnorm_act_pipe.md
BATCHNORM_ACT_PIPE -- requirements
Module: batchnorm_act_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed fixed-point sample/parameter width.
REQ-002 SHALL have parameter FRAC, default 8, meaning fractional bits of every Q-format value (FRAC >= 1).
REQ-003 SHALL have parameter CHANNELS, default 16, meaning per-channel parameter table depth; CH_W = max(1, $clog2(CHANNELS)).
REQ-004 SHALL have port clk, input, 1, meaning sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port en, input, 1, meaning pipeline enable; 0 freezes all stages and forces s_ready=0.
REQ-007 SHALL have port act_mode, input, 2, meaning 00 none, 01 ReLU, 10 ReLU6, 11 hard-swish; sampled per sample at acceptance.
REQ-008 SHALL have ports prm_we (1), prm_addr (CH_W), prm_scale (WIDTH) and prm_bias (WIDTH), all inputs, meaning folded-parameter table write port.
REQ-009 SHALL have ports s_valid (in, 1), s_ready (out, 1), s_data (in, WIDTH) and s_channel (in, CH_W), meaning input stream.
REQ-010 SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, WIDTH), m_channel (out, CH_W) and m_sat (out, 1), meaning output stream; m_sat flags a clamped sample.

Function
REQ-011 SHALL compute y = sat(((x*scale) + (bias<<FRAC) + 2^(FRAC-1)) >>> FRAC), with signed multiply, a 2*WIDTH+2 accumulator, and round-half-up.
REQ-012 SHALL saturate y to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and SHALL set m_sat for that sample when clamping occurs.
REQ-013 SHALL apply the activation after saturation: ReLU max(y,0); ReLU6 clamp(y, 0, 6<<FRAC); hard-swish ((y*clamp(y+(3<<FRAC), 0, 6<<FRAC)) >>> FRAC) * 10923 >>> 16, saturated, with truncating shifts.
REQ-014 SHALL use four stages: S1 table lookup, S2 multiply-add, S3 round/saturate, S4 activation.
REQ-015 SHALL have a fixed latency of 4 cycles from s_valid&&s_ready to m_valid for every act_mode, including mode 00.
REQ-016 SHALL stall globally: advance = en && (!m_valid || m_ready); s_ready = advance; throughput is one sample per cycle while m_ready is held high.
REQ-017 SHALL hold m_data, m_channel and m_sat stable while m_valid=1 and m_ready=0; no sample is lost or duplicated; order is preserved.
REQ-018 SHALL carry the channel and act_mode alongside each sample, so an act_mode change affects only samples accepted afterwards.
REQ-019 SHALL apply a write when prm_we=1, regardless of en or stall, with effect from the next cycle; a sample accepted in the same cycle on the same channel SHALL use the old value.
REQ-020 SHALL ignore writes with prm_addr >= CHANNELS, and SHALL process samples with s_channel >= CHANNELS using scale=1<<FRAC and bias=0.
REQ-021 SHALL drive m_data=0, m_channel=0 and m_sat=0 whenever m_valid=0.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, clear all stage valids and set m_valid=0, m_data=0, m_channel=0, m_sat=0 and s_ready=0 during reset.
REQ-023 SHALL reset every table entry to scale=1<<FRAC and bias=0, and SHALL discard in-flight samples on reset mid-stream.
REQ-024 SHALL assert s_ready in the first cycle after rst_n rises, if en=1.

Structure
REQ-025 SHALL place the act_mode enum, the ONE/THREE/SIX Q-format constants, INV6=10923 and the sat() function in shared package bn_pkg.
REQ-026 SHALL implement the activation stage S4 as sub-module bn_act_unit, which has its own valid/stall inputs.
REQ-027 SHALL hold the parameter table in registers with one write port and one read port.

Verification (WIDTH=16, FRAC=8)
REQ-028 SHALL test: write ch3 scale=0x0200, bias=0x0080; send x=0x0100 on ch3 in mode 00 -> m_data=0x0280 exactly 4 cycles later, m_sat=0.
REQ-029 SHALL test: scale=0x7FFF, x=0x7FFF -> m_data=0x7FFF, m_sat=1; x=0x8000 with the same scale -> m_data=0x8000, m_sat=1.
REQ-030 SHALL test: identity params with mode 01 and x=0xFF00 -> 0x0000; mode 10 and x=0x0800 -> 0x0600; mode 11 and x=0x0100 -> 0x00AA.
REQ-031 SHALL test: a 32-sample stream with m_ready toggled randomly and held low for 5 cycles -> all 32 outputs in order, correct, and held stable while stalled.
REQ-032 SHALL test: a same-cycle prm_we and sample on ch5 -> the old value is used, and the next sample on ch5 uses the new value; s_channel=CHANNELS -> the sample passes through unchanged.
REQ-033 SHALL test: rst_n low for 1 cycle with 3 samples in flight -> no m_valid afterwards until new input, and the table is back to identity.
